// File: rtl/filter_ram_ctrl_if.sv
// Bundles the result stream, readout client and RAM port signals of filter_ram_ctrl.
// slave = controller view, master = environment (datapath, readout client, RAM) view.
interface filter_ram_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              ram_wr;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_nextaddr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [31:0]       ram_dout;

    modport slave (
        input  res_valid, res_data, rd_req, rd_addr, ram_dout,
        output res_ready, rd_ready, rd_valid, rd_data,
        output ram_wr, ram_rd, ram_nextaddr, ram_addr, ram_din
    );

    modport master (
        output res_valid, res_data, rd_req, rd_addr, ram_dout,
        input  res_ready, rd_ready, rd_valid, rd_data,
        input  ram_wr, ram_rd, ram_nextaddr, ram_addr, ram_din
    );
endinterface

// File: rtl/filter_ram_ctrl.sv
// Frame write sequencer and shared read port for the 256x32 filter-output RAM.
// Optional FILTER_RAM_CTRL_OVF_EN: accept-and-discard results in DONE with sticky ovf flag.
module filter_ram_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    filter_ram_ctrl_if.slave  bus,
    output logic              busy,
    output logic              frame_done,
`ifdef FILTER_RAM_CTRL_OVF_EN
    output logic              ovf,
`endif
    output logic [ADDR_W:0]   wcount
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(FRAME_LEN - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W:0]   wcount_q;
    logic              rd_valid_q;
    logic              res_ready;
    logic              accept;
    logic              wr_en;
    logic              rd_ok;
`ifdef FILTER_RAM_CTRL_OVF_EN
    logic              ovf_q;
`endif

    always_comb begin
`ifdef FILTER_RAM_CTRL_OVF_EN
        res_ready = (state_q == FILL) || (state_q == DONE);
`else
        res_ready = (state_q == FILL);
`endif
        accept = bus.res_valid & res_ready;
        wr_en  = accept & (state_q == FILL);
        // Only a real RAM write can collide; discarded overflow results never stall a read.
        rd_ok  = bus.rd_req & ~(wr_en & (bus.rd_addr == wptr_q)) & ~rst;
    end

    assign bus.res_ready    = res_ready;
    assign bus.ram_wr       = wr_en;
    assign bus.ram_nextaddr = wr_en ? wptr_q : '0;
    assign bus.ram_din      = wr_en ? bus.res_data : '0;
    assign bus.rd_ready     = rd_ok;
    assign bus.ram_rd       = rd_ok;
    assign bus.ram_addr     = rd_ok ? bus.rd_addr : '0;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_valid_q ? bus.ram_dout : '0;
    assign busy             = (state_q == FILL);
    assign frame_done       = (state_q == DONE);
    assign wcount           = wcount_q;
`ifdef FILTER_RAM_CTRL_OVF_EN
    assign ovf              = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            wcount_q   <= '0;
            rd_valid_q <= 1'b0;
`ifdef FILTER_RAM_CTRL_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            rd_valid_q <= rd_ok;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FILL;
                        wptr_q   <= '0;
                        wcount_q <= '0;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wcount_q <= wcount_q + 1'b1;
                        // wptr stays on the last address so it never runs past the frame.
                        if (wcount_q == LAST) state_q <= DONE;
                        else                  wptr_q  <= wptr_q + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q  <= FILL;
                        wptr_q   <= '0;
                        wcount_q <= '0;
`ifdef FILTER_RAM_CTRL_OVF_EN
                        ovf_q    <= 1'b0;
                    end else if (accept) begin
                        ovf_q    <= 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_ram_ctrl.sv
// Randomized bench for filter_ram_ctrl with a frame-level reference model and RAM model.
module tb_filter_ram_ctrl;
    localparam int FRAME_LEN = 9;
`ifdef FILTER_RAM_CTRL_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, frame_done;
    logic [8:0] wcount;
`ifdef FILTER_RAM_CTRL_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    filter_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    filter_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done),
`ifdef FILTER_RAM_CTRL_OVF_EN
        .ovf(ovf),
`endif
        .wcount(wcount)
    );

    always #5 clk = ~clk;

    // RAM: registered read, synchronous write, zero-extended data.
    logic [31:0] mem [256];
    logic [31:0] dout_q = '0;
    assign bus.ram_dout = dout_q;
    always @(posedge clk) begin
        if (bus.ram_rd) dout_q <= mem[bus.ram_addr];
        if (bus.ram_wr) mem[bus.ram_nextaddr] <= {24'b0, bus.ram_din};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "started" and holds count results; wptr is the count.
    logic [31:0] exp_mem [256];
    bit          started = 1'b0;
    int          count = 0;
    bit          rdv = 1'b0;
    logic [31:0] rdval = '0;
    bit          ovf_m = 1'b0;

    always @(posedge clk) begin
        bit filling, done, wr, rdok;
        if (rst) begin
            started = 1'b0; count = 0; rdv = 1'b0; ovf_m = 1'b0;
        end else begin
            filling = started && count < FRAME_LEN;
            done    = started && count == FRAME_LEN;
            wr      = bus.res_valid && filling;
            rdok    = bus.rd_req && !(wr && int'(bus.rd_addr) == count);
            rdv     = rdok;
            if (rdok) rdval = exp_mem[bus.rd_addr];
            if (OVF && done && bus.res_valid) ovf_m = 1'b1;
            if (wr) begin
                exp_mem[count] = {24'b0, bus.res_data};
                count++;
            end
            if (start && !filling) begin
                started = 1'b1; count = 0; ovf_m = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit filling, done, wr, rdr;
        filling = started && count < FRAME_LEN;
        done    = started && count == FRAME_LEN;
        wr      = bus.res_valid && filling;
        rdr     = bus.rd_req && !(wr && int'(bus.rd_addr) == count) && !rst;
        chk("res_ready", {31'b0, bus.res_ready}, {31'b0, filling || (OVF && done)});
        chk("ram_wr", {31'b0, bus.ram_wr}, {31'b0, wr});
        if (wr) begin
            chk("ram_nextaddr", {24'b0, bus.ram_nextaddr}, count);
            chk("ram_din", {24'b0, bus.ram_din}, {24'b0, bus.res_data});
        end
        chk("rd_ready", {31'b0, bus.rd_ready}, {31'b0, rdr});
        chk("ram_rd", {31'b0, bus.ram_rd}, {31'b0, rdr});
        if (rdr) chk("ram_addr", {24'b0, bus.ram_addr}, {24'b0, bus.rd_addr});
        chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, rdv});
        if (rdv) chk("rd_data", bus.rd_data, rdval);
        chk("busy", {31'b0, busy}, {31'b0, filling});
        chk("frame_done", {31'b0, frame_done}, {31'b0, done});
        chk("wcount", {23'b0, wcount}, count);
`ifdef FILTER_RAM_CTRL_OVF_EN
        chk("ovf", {31'b0, ovf}, {31'b0, ovf_m});
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
    endtask

    logic [7:0] vals [9] = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd2, 8'd3, 8'd5, 8'd6, 8'd4};

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("lit_reset_busy", {31'b0, busy}, 32'd0);
        chk("lit_reset_done", {31'b0, frame_done}, 32'd0);
        chk("lit_reset_wcount", {23'b0, wcount}, 32'd0);
        chk("lit_reset_rd_valid", {31'b0, bus.rd_valid}, 32'd0);

        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.res_valid = 1'b1; bus.res_data = vals[i];
            #1;
            chk("lit_frame_wr", {31'b0, bus.ram_wr}, 32'd1);
            chk("lit_frame_addr", {24'b0, bus.ram_nextaddr}, i);
            tick();
        end
        bus.res_valid = 1'b0;
        #1;
        chk("lit_frame_done", {31'b0, frame_done}, 32'd1);
        chk("lit_frame_wcount", {23'b0, wcount}, 32'd9);

        bus.res_valid = 1'b1; bus.res_data = 8'hAA;
        #1;
        chk("lit_excess_ready", {31'b0, bus.res_ready}, {31'b0, OVF});
        chk("lit_excess_wr", {31'b0, bus.ram_wr}, 32'd0);
        tick();
        bus.res_valid = 1'b0;
`ifdef FILTER_RAM_CTRL_OVF_EN
        #1;
        chk("lit_ovf_set", {31'b0, ovf}, 32'd1);
`endif

        bus.rd_req = 1'b1; bus.rd_addr = 8'd3;
        #1;
        chk("lit_read_ready", {31'b0, bus.rd_ready}, 32'd1);
        tick();
        bus.rd_req = 1'b0;
        #1;
        chk("lit_read_valid", {31'b0, bus.rd_valid}, 32'd1);
        chk("lit_read_data", bus.rd_data, 32'h5);
        tick();

        start = 1'b1; tick(); start = 1'b0;
`ifdef FILTER_RAM_CTRL_OVF_EN
        chk("lit_ovf_clear", {31'b0, ovf}, 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1; bus.res_data = 8'(8'h10 + i);
            tick();
        end
        bus.res_data = 8'h77; bus.rd_req = 1'b1; bus.rd_addr = 8'd4;
        #1;
        chk("lit_hazard_stall", {31'b0, bus.rd_ready}, 32'd0);
        chk("lit_hazard_wr_addr", {24'b0, bus.ram_nextaddr}, 32'd4);
        tick();
        bus.res_data = 8'h78;
        #1;
        chk("lit_hazard_accept", {31'b0, bus.rd_ready}, 32'd1);
        tick();
        bus.res_valid = 1'b0; bus.rd_req = 1'b0;
        #1;
        chk("lit_hazard_valid", {31'b0, bus.rd_valid}, 32'd1);
        chk("lit_hazard_data", bus.rd_data, 32'h77);

        rst = 1'b1; tick(); tick(); rst = 1'b0;
        #1;
        chk("lit_midreset_busy", {31'b0, busy}, 32'd0);
        chk("lit_midreset_wcount", {23'b0, wcount}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.res_valid = 1'b1; bus.res_data = 8'(8'h30 + i);
            #1;
            chk("lit_restart_addr", {24'b0, bus.ram_nextaddr}, i);
            tick();
        end
        bus.res_valid = 1'b0;
        #1;
        chk("lit_restart_done", {31'b0, frame_done}, 32'd1);

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (rst) begin
                idle_inputs();
            end else begin
                start         = ($urandom_range(0, 19) == 0);
                bus.res_valid = ($urandom_range(0, 1) == 1);
                bus.res_data  = 8'($urandom);
                bus.rd_req    = ($urandom_range(0, 9) < 4);
                bus.rd_addr   = 8'($urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
